// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states, flag layout
// and the even-parity helper.
package alu_mc_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_ADC  = 4'd1,
      OP_SUB  = 4'd2,
      OP_SBB  = 4'd3,
      OP_AND  = 4'd4,
      OP_OR   = 4'd5,
      OP_XOR  = 4'd6,
      OP_ANDN = 4'd7,
      OP_SHL  = 4'd8,
      OP_SHR  = 4'd9,
      OP_SAR  = 4'd10,
      OP_ROL  = 4'd11,
      OP_ROR  = 4'd12,
      OP_MULU = 4'd13,
      OP_DIVU = 4'd14
   } alu_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } alu_state_t;

   typedef struct packed {
      logic cf;
      logic zf;
      logic of;
      logic sf;
      logic pf;
   } flags_t;

   // Widest word the parity helper handles; narrower words are zero-extended,
   // which leaves the count of ones unchanged.
   localparam int PARITY_MAX_W = 64;

   // 1 when the number of set bits is even.
   function automatic logic parity_even(input logic [PARITY_MAX_W-1:0] v);
      return ~^v;
   endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine.
// One step per cycle for WORD_WIDTH cycles after start; done is high in the
// last step cycle and res_hi/res_lo then carry the final (post-step) value.
module alu_mc_iter
   import alu_mc_pkg::*;
#(
   parameter int WORD_WIDTH = 16
)
(
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  start,
   input  logic                  mode,      // 0: multiply, 1: divide
   input  logic [WORD_WIDTH-1:0] a,
   input  logic [WORD_WIDTH-1:0] b,
   output logic                  done,
   output logic [WORD_WIDTH-1:0] res_hi,
   output logic [WORD_WIDTH-1:0] res_lo
);

   localparam int CNT_W = $clog2(WORD_WIDTH) + 1;

   logic [CNT_W-1:0]      count_reg;
   logic                  mode_reg;
   logic [WORD_WIDTH-1:0] b_reg;
   logic [WORD_WIDTH-1:0] hi_reg, lo_reg;
   logic [WORD_WIDTH-1:0] hi_next, lo_next;
   logic [WORD_WIDTH:0]   mul_sum;
   logic [WORD_WIDTH:0]   div_trial;
   logic [WORD_WIDTH-1:0] div_diff;
   logic                  div_ge;

   // One datapath step: mul adds multiplicand on lo[0] then shifts the pair
   // right; div shifts the pair left and keeps the trial subtraction if it fits.
   always_comb begin
      mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
      div_trial = {hi_reg, lo_reg[WORD_WIDTH-1]};
      div_ge    = (div_trial >= {1'b0, b_reg});
      // When the trial fits, trial - b < b, so the low word holds it exactly.
      div_diff  = div_trial[WORD_WIDTH-1:0] - b_reg;
      hi_next   = hi_reg;
      lo_next   = lo_reg;
      if (mode_reg) begin
         hi_next = div_ge ? div_diff : div_trial[WORD_WIDTH-1:0];
         lo_next = {lo_reg[WORD_WIDTH-2:0], div_ge};
      end else begin
         {hi_next, lo_next} = {mul_sum, lo_reg[WORD_WIDTH-1:1]};
      end
   end

   // Operand capture on start, then step and count down to zero.
   always_ff @(posedge clk) begin
      if (srst) begin
         count_reg <= '0;
         mode_reg  <= 1'b0;
         b_reg     <= '0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else if (start) begin
         count_reg <= CNT_W'(WORD_WIDTH);
         mode_reg  <= mode;
         b_reg     <= b;
         hi_reg    <= '0;
         lo_reg    <= a;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - CNT_W'(1);
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
      end
   end

   assign done   = (count_reg == CNT_W'(1));
   assign res_hi = hi_next;
   assign res_lo = lo_next;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU core: valid/ready on both sides, registered single-cycle
// ops, iterative MULU/DIVU via alu_mc_iter, and the committed flag register.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int WORD_WIDTH = 16
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [3:0]            op_i,
   input  logic [WORD_WIDTH-1:0] a_i,
   input  logic [WORD_WIDTH-1:0] b_i,
   input  logic                  flag_we_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WORD_WIDTH-1:0] r_o,
   output logic [WORD_WIDTH-1:0] r_hi_o,
   output logic                  cf_o,
   output logic                  zf_o,
   output logic                  of_o,
   output logic                  sf_o,
   output logic                  pf_o
);

   localparam int SHAMT_W = $clog2(WORD_WIDTH);
   localparam int MSB     = WORD_WIDTH - 1;

   alu_op_t               op;
   alu_state_t            state_reg, state_next;
   logic                  ready;
   logic                  accept;
   logic                  is_muldiv;
   logic                  load_sc, load_it;

   logic                  valid_reg;
   logic [WORD_WIDTH-1:0] r_reg, r_hi_reg;
   flags_t                flags_reg;

   logic                  fwe_reg, div_reg, bzero_reg;
   logic                  iter_done;
   logic [WORD_WIDTH-1:0] iter_hi, iter_lo;
   flags_t                it_flags;

   logic [WORD_WIDTH:0]   sum, diff;
   logic                  cin, bin;
   logic [SHAMT_W-1:0]    amt;
   logic [SHAMT_W:0]      inv_amt;
   logic [WORD_WIDTH:0]   shl_full, shr_full, sar_full;
   logic [WORD_WIDTH-1:0] rol_res, ror_res;
   logic [WORD_WIDTH-1:0] sc_r;
   logic                  cf_n, of_n, sc_upd;
   flags_t                sc_flags;

   assign op        = alu_op_t'(op_i);
   assign is_muldiv = (op == OP_MULU) || (op == OP_DIVU);
   assign ready     = ~rst_i & (state_reg == IDLE) & (~valid_reg | ready_i);
   assign accept    = valid_i & ready;
   assign load_sc   = accept & ~is_muldiv;
   assign load_it   = (state_reg == BUSY) & iter_done;

   alu_mc_iter #(.WORD_WIDTH(WORD_WIDTH)) u_iter (
      .clk    (clk_i),
      .srst   (rst_i),
      .start  (accept & is_muldiv),
      .mode   (op == OP_DIVU),
      .a      (a_i),
      .b      (b_i),
      .done   (iter_done),
      .res_hi (iter_hi),
      .res_lo (iter_lo)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next state: BUSY for the whole iterative run, back to IDLE on its last step.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept && is_muldiv) state_next = BUSY;
         BUSY:    if (iter_done)           state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Single-cycle datapath; cf/of default to the committed values so shifts
   // by zero leave them alone.
   always_comb begin
      cin      = (op == OP_ADC) & flags_reg.cf;
      bin      = (op == OP_SBB) & flags_reg.cf;
      sum      = {1'b0, a_i} + {1'b0, b_i} + {{WORD_WIDTH{1'b0}}, cin};
      diff     = {1'b0, a_i} - {1'b0, b_i} - {{WORD_WIDTH{1'b0}}, bin};
      amt      = b_i[SHAMT_W-1:0];
      inv_amt  = (SHAMT_W+1)'(WORD_WIDTH) - {1'b0, amt};
      shl_full = {1'b0, a_i} << amt;
      shr_full = {a_i, 1'b0} >> amt;
      sar_full = $signed({a_i, 1'b0}) >>> amt;
      rol_res  = (a_i << amt) | (a_i >> inv_amt);
      ror_res  = (a_i >> amt) | (a_i << inv_amt);
      sc_r     = '0;
      cf_n     = flags_reg.cf;
      of_n     = flags_reg.of;
      sc_upd   = flag_we_i;
      case (op)
         OP_ADD, OP_ADC: begin
            sc_r = sum[MSB:0];
            cf_n = sum[WORD_WIDTH];
            of_n = (a_i[MSB] == b_i[MSB]) & (sum[MSB] != a_i[MSB]);
         end
         OP_SUB, OP_SBB: begin
            sc_r = diff[MSB:0];
            cf_n = diff[WORD_WIDTH];
            of_n = (a_i[MSB] != b_i[MSB]) & (diff[MSB] != a_i[MSB]);
         end
         OP_AND:  begin sc_r = a_i & b_i;  cf_n = 1'b0; of_n = 1'b0; end
         OP_OR:   begin sc_r = a_i | b_i;  cf_n = 1'b0; of_n = 1'b0; end
         OP_XOR:  begin sc_r = a_i ^ b_i;  cf_n = 1'b0; of_n = 1'b0; end
         OP_ANDN: begin sc_r = a_i & ~b_i; cf_n = 1'b0; of_n = 1'b0; end
         OP_SHL:  begin sc_r = shl_full[MSB:0];        cf_n = shl_full[WORD_WIDTH]; end
         OP_SHR:  begin sc_r = shr_full[WORD_WIDTH:1]; cf_n = shr_full[0]; end
         OP_SAR:  begin sc_r = sar_full[WORD_WIDTH:1]; cf_n = sar_full[0]; end
         OP_ROL:  begin sc_r = rol_res; cf_n = rol_res[0]; end
         OP_ROR:  begin sc_r = ror_res; cf_n = ror_res[MSB]; end
         default: sc_upd = 1'b0;
      endcase
      if (op inside {OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR}) begin
         if (amt == '0) begin
            sc_r = a_i;
            cf_n = flags_reg.cf;
            of_n = flags_reg.of;
         end else begin
            of_n = (amt == SHAMT_W'(1)) ? (sc_r[MSB] ^ a_i[MSB]) : 1'b0;
         end
      end
      sc_flags.cf = cf_n;
      sc_flags.of = of_n;
      sc_flags.zf = (sc_r == '0);
      sc_flags.sf = sc_r[MSB];
      sc_flags.pf = parity_even(PARITY_MAX_W'(sc_r));
   end

   // Flags for the iterative result: carry/overflow mark a non-zero high
   // product word, or a divide by zero.
   always_comb begin
      it_flags.zf = (iter_lo == '0);
      it_flags.sf = iter_lo[MSB];
      it_flags.pf = parity_even(PARITY_MAX_W'(iter_lo));
      if (div_reg) begin
         it_flags.cf = 1'b0;
         it_flags.of = bzero_reg;
      end else begin
         it_flags.cf = |iter_hi;
         it_flags.of = |iter_hi;
      end
   end

   // Per-operation attributes of an iterative op, held until it completes.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fwe_reg   <= 1'b0;
         div_reg   <= 1'b0;
         bzero_reg <= 1'b0;
      end else if (accept && is_muldiv) begin
         fwe_reg   <= flag_we_i;
         div_reg   <= (op == OP_DIVU);
         bzero_reg <= (b_i == '0);
      end
   end

   // Output register and committed flags; results hold until the consumer
   // takes them, and a fresh load in the handshake edge keeps valid high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_reg <= 1'b0;
         r_reg     <= '0;
         r_hi_reg  <= '0;
         flags_reg <= '0;
      end else if (load_sc) begin
         valid_reg <= 1'b1;
         r_reg     <= sc_r;
         r_hi_reg  <= '0;
         if (sc_upd) flags_reg <= sc_flags;
      end else if (load_it) begin
         valid_reg <= 1'b1;
         r_reg     <= iter_lo;
         r_hi_reg  <= iter_hi;
         if (fwe_reg) flags_reg <= it_flags;
      end else if (ready_i) begin
         valid_reg <= 1'b0;
      end
   end

   assign ready_o = ready;
   assign valid_o = valid_reg;
   assign r_o     = r_reg;
   assign r_hi_o  = r_hi_reg;
   assign cf_o    = flags_reg.cf;
   assign zf_o    = flags_reg.zf;
   assign of_o    = flags_reg.of;
   assign sf_o    = flags_reg.sf;
   assign pf_o    = flags_reg.pf;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WORD_WIDTH=8: directed test-plan sequences, then
// random ops with random back-pressure, checked against a behavioural model.
module tb_alu_mc;
   import alu_mc_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_i = 1'b1;
   logic         valid_i = 1'b0;
   logic         ready_o;
   logic [3:0]   op_i = 4'd0;
   logic [W-1:0] a_i = '0, b_i = '0;
   logic         flag_we_i = 1'b0;
   logic         valid_o;
   logic         ready_i = 1'b1;
   logic [W-1:0] r_o, r_hi_o;
   logic         cf_o, zf_o, of_o, sf_o, pf_o;

   alu_mc #(.WORD_WIDTH(W)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
      .op_i(op_i), .a_i(a_i), .b_i(b_i), .flag_we_i(flag_we_i),
      .valid_o(valid_o), .ready_i(ready_i), .r_o(r_o), .r_hi_o(r_hi_o),
      .cf_o(cf_o), .zf_o(zf_o), .of_o(of_o), .sf_o(sf_o), .pf_o(pf_o)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] r; logic [7:0] rhi; logic [4:0] fl; int lat; } mres_t;
   typedef struct { logic [7:0] r; logic [7:0] rhi; logic [4:0] fl; int vis; } exp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   rdy_mode = 0;       // 0: always ready, 1: random, 2: held low
   int   busy_end = 0;
   logic prev_rst = 1'b1;
   logic [4:0] mflags = 5'b0; // {cf,zf,of,sf,pf}
   exp_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Specification-level model: plain integer arithmetic on the operands.
   function automatic mres_t model(input logic [3:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input logic fwe,
                                   input logic [4:0] fl);
      mres_t m;
      int ia, ib, sa, sb, t, n, c;
      logic cf, of, upd;
      ia = int'(a); ib = int'(b);
      sa = ia - (a[7] ? 256 : 0);
      sb = ib - (b[7] ? 256 : 0);
      n  = ib % 8;
      cf = fl[4]; of = fl[2]; upd = 1'b1;
      m.r = 8'h00; m.rhi = 8'h00; m.lat = 1;
      if (op == OP_ADD || op == OP_ADC) begin
         c = (op == OP_ADC) ? int'(fl[4]) : 0;
         t = ia + ib + c; m.r = t[7:0]; cf = (t > 255);
         t = sa + sb + c; of = (t > 127) || (t < -128);
      end else if (op == OP_SUB || op == OP_SBB) begin
         c = (op == OP_SBB) ? int'(fl[4]) : 0;
         t = ia - ib - c; m.r = t[7:0]; cf = (t < 0);
         t = sa - sb - c; of = (t > 127) || (t < -128);
      end else if (op == OP_AND)  begin m.r = a & b;  cf = 0; of = 0;
      end else if (op == OP_OR)   begin m.r = a | b;  cf = 0; of = 0;
      end else if (op == OP_XOR)  begin m.r = a ^ b;  cf = 0; of = 0;
      end else if (op == OP_ANDN) begin m.r = a & ~b; cf = 0; of = 0;
      end else if (op >= OP_SHL && op <= OP_ROR) begin
         if (n == 0) m.r = a;
         else begin
            if (op == OP_SHL) begin t = ia << n; m.r = t[7:0]; cf = t[8]; end
            else if (op == OP_SHR) begin t = ia >> n; m.r = t[7:0]; cf = ((ia >> (n-1)) & 1) != 0; end
            else if (op == OP_SAR) begin t = sa >>> n; m.r = t[7:0]; cf = ((ia >> (n-1)) & 1) != 0; end
            else if (op == OP_ROL) begin t = (ia << n) | (ia >> (8-n)); m.r = t[7:0]; cf = m.r[0]; end
            else begin t = (ia >> n) | (ia << (8-n)); m.r = t[7:0]; cf = m.r[7]; end
            of = (n == 1) && (m.r[7] != a[7]);
         end
      end else if (op == OP_MULU) begin
         t = ia * ib; m.r = t[7:0]; m.rhi = t[15:8];
         cf = (m.rhi != 0); of = cf; m.lat = W + 1;
      end else if (op == OP_DIVU) begin
         m.lat = W + 1; cf = 0;
         if (ib == 0) begin m.r = 8'hFF; m.rhi = a; of = 1; end
         else begin t = ia / ib; m.r = t[7:0]; t = ia % ib; m.rhi = t[7:0]; of = 0; end
      end else begin
         upd = 1'b0;
      end
      if (fwe && upd) m.fl = {cf, (m.r == 8'h00), of, m.r[7], ~^m.r};
      else            m.fl = fl;
      return m;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Consumer-side ready driver.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       ready_i = 1'b1;
         1:       ready_i = ($urandom_range(0, 3) != 0);
         default: ready_i = 1'b0;
      endcase
   end

   // Compare process: every cycle, checks handshake outputs and any visible
   // result against the model, then records a newly accepted request.
   always @(negedge clk) begin
      logic  exp_valid, exp_ready;
      mres_t m;
      exp_t  e;
      if (rst_i) begin
         chk("ready_in_reset", {31'b0, ready_o}, 32'd0);
         q.delete();
         mflags   = 5'b0;
         busy_end = 0;
         prev_rst = 1'b1;
      end else begin
         if (prev_rst) begin
            chk("post_reset_valid", {31'b0, valid_o}, 32'd0);
            chk("post_reset_flags", {27'b0, cf_o, zf_o, of_o, sf_o, pf_o}, 32'd0);
            chk("post_reset_r", {16'b0, r_hi_o, r_o}, 32'd0);
         end
         exp_valid = (q.size() > 0) && (cyc >= q[0].vis);
         exp_ready = (cyc >= busy_end) && (!exp_valid || ready_i);
         chk("valid_o", {31'b0, valid_o}, {31'b0, exp_valid});
         chk("ready_o", {31'b0, ready_o}, {31'b0, exp_ready});
         if (valid_o && exp_valid) begin
            $display("result cycle %0d: r=%h r_hi=%h flags=%b (exp %h %h %b)", cyc,
                     r_o, r_hi_o, {cf_o, zf_o, of_o, sf_o, pf_o}, q[0].r, q[0].rhi, q[0].fl);
            chk("r_o", {24'b0, r_o}, {24'b0, q[0].r});
            chk("r_hi_o", {24'b0, r_hi_o}, {24'b0, q[0].rhi});
            chk("flags", {27'b0, cf_o, zf_o, of_o, sf_o, pf_o}, {27'b0, q[0].fl});
         end
         if (exp_valid && ready_i) void'(q.pop_front());
         if (valid_i && ready_o) begin
            m = model(op_i, a_i, b_i, flag_we_i, mflags);
            mflags = m.fl;
            e.r = m.r; e.rhi = m.rhi; e.fl = m.fl; e.vis = cyc + m.lat;
            q.push_back(e);
            if (m.lat > 1) busy_end = cyc + m.lat;
         end
         prev_rst = 1'b0;
      end
   end

   // Present one request and hold it until accepted.
   task automatic issue(input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic fwe);
      int k;
      valid_i = 1'b1; op_i = op; a_i = a; b_i = b; flag_we_i = fwe;
      k = 0;
      @(negedge clk);
      while (!ready_o && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         n_err++;
         $display("FAIL accept_timeout @cycle %0d: op %0d not accepted, required within 200 cycles", cyc, op);
      end
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   initial begin
      mres_t p;
      logic [3:0] rop;
      logic [7:0] ra, rb;
      // Hand-computed pins on the model itself.
      p = model(OP_ADD, 8'h7F, 8'h01, 1'b1, 5'b0);
      chk("pin_add_r", {24'b0, p.r}, 32'h80);
      chk("pin_add_fl", {27'b0, p.fl}, 32'b00110);
      p = model(OP_SHL, 8'h81, 8'h01, 1'b1, 5'b00110);
      chk("pin_shl_r", {24'b0, p.r}, 32'h02);
      chk("pin_shl_cf", {31'b0, p.fl[4]}, 32'd1);
      p = model(OP_SBB, 8'h05, 8'h02, 1'b1, 5'b10011);
      chk("pin_sbb_r", {24'b0, p.r}, 32'h02);
      p = model(OP_MULU, 8'h10, 8'h20, 1'b1, 5'b0);
      chk("pin_mul", {19'b0, p.fl, p.rhi, p.r}, {19'b0, 5'b11101, 8'h02, 8'h00});
      p = model(OP_DIVU, 8'd100, 8'd7, 1'b1, 5'b0);
      chk("pin_div", {16'b0, p.rhi, p.r}, 32'h020E);
      p = model(OP_DIVU, 8'h35, 8'h00, 1'b1, 5'b0);
      chk("pin_div0", {11'b0, p.fl[2], 4'b0, p.rhi, p.r}, {11'b0, 1'b1, 4'b0, 16'h35FF});

      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(posedge clk); #1;

      // Test-plan sequences.
      issue(OP_ADD, 8'h7F, 8'h01, 1'b1);
      issue(OP_SHL, 8'h81, 8'h01, 1'b1);
      issue(OP_SUB, 8'h00, 8'h01, 1'b1);
      issue(OP_SBB, 8'h05, 8'h02, 1'b1);
      issue(OP_MULU, 8'h10, 8'h20, 1'b1);
      issue(OP_DIVU, 8'd100, 8'd7, 1'b1);
      issue(OP_DIVU, 8'h35, 8'h00, 1'b1);
      issue(OP_XOR, 8'hF0, 8'h0F, 1'b1);
      issue(4'd15, 8'h12, 8'h34, 1'b1);

      // Back-pressure: three back-to-back ADDs with the consumer stalled.
      rdy_mode = 2;
      issue(OP_ADD, 8'h11, 8'h22, 1'b1);
      fork
         begin repeat (3) @(posedge clk); rdy_mode = 0; end
      join_none
      issue(OP_ADD, 8'h33, 8'h44, 1'b1);
      issue(OP_ADD, 8'hF0, 8'h20, 1'b1);

      // Reset four cycles into a multiply.
      issue(OP_MULU, 8'h10, 8'h20, 1'b1);
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk); #1 rst_i = 1'b0;
      issue(OP_ADD, 8'h01, 8'h01, 1'b1);

      // Randomized phase with random back-pressure.
      rdy_mode = 1;
      for (int i = 0; i < 400; i++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = 8'($urandom);
         rb  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         issue(rop, ra, rb, ($urandom_range(0, 4) != 0));
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      end

      rdy_mode = 0;
      repeat (W + 4) @(posedge clk);
      @(negedge clk);
      chk("all_results_delivered", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle ALU core that replaces the purely combinational per-unit ALU.
- Single-cycle ops (add/logic/shift/rotate) have a registered result.
- Iterative unsigned multiply/divide run as a sequential engine.
- An architectural flag register is held internally and feeds carry-in.
- Sits between decode/issue and writeback, with valid/ready handshakes on both sides.

Parameters:
WORD_WIDTH, 16, operand/result width; power of two, >= 4.
SHAMT_W, $clog2(WORD_WIDTH), shift-amount width (derived, not overridden).

Ports:
clk_i  in  1  clock; all state on rising edge.
rst_i  in  1  synchronous, active-high reset.
valid_i  in  1  operation request valid.
ready_o  out  1  core can accept a request this cycle.
op_i  in  4  opcode (alu_op_t).
a_i  in  WORD_WIDTH  operand A.
b_i  in  WORD_WIDTH  operand B; for shifts, b_i[SHAMT_W-1:0] is the amount.
flag_we_i  in  1  commit flags for this op.
valid_o  out  1  result valid.
ready_i  in  1  consumer accepts result.
r_o  out  WORD_WIDTH  result, or low product word, or quotient.
r_hi_o  out  WORD_WIDTH  high product word or remainder; 0 for other ops.
cf_o, zf_o, of_o, sf_o, pf_o  out  1 each  committed flag register.

Behaviour:
- Reset: state IDLE; valid_o=0, r_o=0, r_hi_o=0, all flags=0; ready_o=0 while rst_i=1. An in-flight mul/div is discarded.
- Accept: valid_i & ready_o. ready_o = (state==IDLE) & (~valid_o | ready_i), giving back-to-back single-cycle throughput.
- Single-cycle ops: ADD, ADC, SUB, SBB, AND, OR, XOR, ANDN, SHL, SHR, SAR, ROL, ROR.
  - Result and r_hi_o=0 are loaded on the edge ending the accept cycle, so valid_o is high the next cycle.
- MULU, DIVU: state goes IDLE->BUSY with counter=WORD_WIDTH.
  - One shift-add (mul) or restoring-subtract (div) step per cycle.
  - At counter==1 the output register loads and state goes BUSY->IDLE.
  - valid_o rises exactly WORD_WIDTH+1 cycles after the accept cycle.
  - ready_o=0 throughout BUSY.
- Output hold: while valid_o & ~ready_i, r_o, r_hi_o and valid_o are stable. valid_o drops after the handshake unless a new result loads in the same edge.
- Flags: computed from the final result and written on the same edge the output register loads, only if flag_we_i was set at accept (flag_we_i is captured at accept for mul/div).
  - ADC/SBB use the committed cf, so an op accepted in the cycle after a load sees the updated carry.
- Flag rules:
  - zf = (r==0).
  - sf = r[MSB].
  - pf = ~^r (1 when the number of ones is even).
  - ADD/ADC: cf = carry out; of = signed overflow.
  - SUB/SBB: cf = borrow; of = signed overflow.
  - Logic ops: cf=0, of=0.
  - Shifts/rotates: cf = last bit shifted out; of = MSB changed for amount 1, else 0. Amount 0 gives r=a with cf and of unchanged.
  - SAR fills with a[MSB]; rotates are modulo WORD_WIDTH.
  - MULU: r=product[W-1:0], r_hi=product[2W-1:W]; cf=of=(r_hi!=0); zf/sf/pf from r.
  - DIVU: r=quotient, r_hi=remainder.
  - DIVU with b=0: no iteration skip, same latency; r=all ones, r_hi=a, of=1, cf=0.
- Unused opcodes: single-cycle, r=0, flags untouched regardless of flag_we_i.
- valid_i while ready_o=0 is ignored; the requester must hold it.

Decomposition:
- alu_mc_pkg holds:
  - alu_op_t enum (4-bit encodings of the ops above).
  - Typedef alu_state_t {IDLE, BUSY}.
  - flags_t packed struct {cf, zf, of, sf, pf}.
  - Function parity_even.
- One sub-module, alu_mc_iter: the iterative mul/div datapath with counter, start/done, a, b and mode inputs, and 2W result outputs. alu_mc keeps the handshake, single-cycle datapath and flag register.

Test Plan (WORD_WIDTH=8):
- ADD 0x7F+0x01 with flag_we=1 -> next cycle valid_o=1, r=0x80, cf0 zf0 of1 sf1 pf0. Then SHL 0x81 by 1 -> r=0x02, cf1.
- SUB 0x00-0x01 -> r=0xFF, cf1. Then back-to-back SBB 0x05-0x02 -> r=0x02, accepted on consecutive cycles.
- MULU 0x10*0x20 -> after 9 cycles r=0x00, r_hi=0x02, cf=of=zf=1; ready_o low for 8 BUSY cycles.
- DIVU 100/7 -> r=0x0E, r_hi=0x02. DIVU 0x35/0 -> r=0xFF, r_hi=0x35, of1, same 9-cycle latency.
- Three back-to-back ADDs with ready_i low 3 cycles -> valid_o and r_o stable, ready_o=0, all three results delivered in order, none lost.
- rst_i asserted 4 cycles into MULU -> next cycle valid_o=0, flags=0, ready_o=1 after release; a following ADD 0x01+0x01 gives r=0x02.
